// File: rtl/edulent_pkg.sv
// edulent_pkg: shared arbiter state type and default memory geometry
package edulent_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int LOCK_MAX_DEF = 16;
  typedef enum logic [2:0] {ARB_IDLE, ARB_CPU, ARB_EXT, ARB_LOCK, ARB_FORCE} arb_state_t;
endpackage

// File: rtl/arb_lock_timer.sv
// arb_lock_timer: counts consecutive locked ext grants, flags the grant that hits the limit
module arb_lock_timer #(
  parameter int LOCK_MAX = 16
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic [CW-1:0] r_cnt;
  assign o_tc = i_en && (r_cnt == CW'(LOCK_MAX - 1));
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + CW'(1);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin CPU/loader arbiter for one synchronous memory port
// with loader burst lock and a bounded lock length that forces a CPU slot.
module mem_arbiter import edulent_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_gnt,
  output logic              o_cpu_rvalid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic              i_ext_req,
  input  logic              i_ext_we,
  input  logic              i_ext_lock,
  input  logic [ADDR_W-1:0] i_ext_addr,
  input  logic [DATA_W-1:0] i_ext_wdata,
  output logic              o_ext_gnt,
  output logic              o_ext_rvalid,
  output logic [DATA_W-1:0] o_ext_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);
  arb_state_t r_state, w_next;
  logic r_rr, r_cpu_rvalid, r_ext_rvalid;
  logic w_force, w_locked, w_lock_gnt, w_tc;
  assign w_force = r_state == ARB_FORCE;
  // a dropped i_ext_lock releases the lock in the same cycle
  assign w_locked = (r_state == ARB_LOCK) && i_ext_lock;
  assign o_cpu_gnt = i_rstn && i_cpu_req && (w_force || (!w_locked && !(i_ext_req && r_rr)));
  assign o_ext_gnt = i_rstn && i_ext_req && (w_force ? !i_cpu_req : (w_locked || !(i_cpu_req && !r_rr)));
  assign o_mem_en = o_cpu_gnt | o_ext_gnt;
  assign o_mem_we = o_ext_gnt ? i_ext_we : (o_cpu_gnt && i_cpu_we);
  assign o_mem_addr = o_ext_gnt ? i_ext_addr : o_cpu_gnt ? i_cpu_addr : '0;
  assign o_mem_wdata = o_ext_gnt ? i_ext_wdata : o_cpu_gnt ? i_cpu_wdata : '0;
  assign w_lock_gnt = o_ext_gnt && i_ext_lock;
  always_comb begin
    w_next = w_lock_gnt ? (w_tc ? ARB_FORCE : ARB_LOCK)
           : o_ext_gnt ? ARB_EXT
           : ((w_force || r_state == ARB_LOCK) && i_ext_lock) ? ARB_LOCK
           : o_cpu_gnt ? ARB_CPU : ARB_IDLE;
  end
  arb_lock_timer #(.LOCK_MAX(LOCK_MAX)) u_lock_timer (
    .i_clk (i_clk),
    .i_rstn(i_rstn),
    .i_en  (w_lock_gnt),
    .i_clr (w_next != ARB_LOCK),
    .o_tc  (w_tc)
  );
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= ARB_IDLE;
      r_rr <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_ext_rvalid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (o_mem_en) r_rr <= o_cpu_gnt;
      r_cpu_rvalid <= o_cpu_gnt && !i_cpu_we;
      r_ext_rvalid <= o_ext_gnt && !i_ext_we;
    end
  end
  assign o_cpu_rvalid = r_cpu_rvalid;
  assign o_ext_rvalid = r_ext_rvalid;
  assign o_cpu_rdata = r_cpu_rvalid ? i_mem_rdata : '0;
  assign o_ext_rdata = r_ext_rvalid ? i_mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a behavioural arbiter/memory model checked every cycle
module tb_mem_arbiter;
  localparam int LM = 16;
  logic i_clk = 1'b0, i_rstn = 1'b0;
  logic i_cpu_req = 1'b0, i_cpu_we = 1'b0;
  logic [7:0] i_cpu_addr = '0, i_cpu_wdata = '0;
  logic i_ext_req = 1'b0, i_ext_we = 1'b0, i_ext_lock = 1'b0;
  logic [7:0] i_ext_addr = '0, i_ext_wdata = '0;
  logic [7:0] i_mem_rdata = '0;
  logic o_cpu_gnt, o_cpu_rvalid, o_ext_gnt, o_ext_rvalid, o_mem_en, o_mem_we;
  logic [7:0] o_cpu_rdata, o_ext_rdata, o_mem_addr, o_mem_wdata;
  int checks = 0, errors = 0;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .LOCK_MAX(LM)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata),
    .o_cpu_gnt(o_cpu_gnt), .o_cpu_rvalid(o_cpu_rvalid), .o_cpu_rdata(o_cpu_rdata),
    .i_ext_req(i_ext_req), .i_ext_we(i_ext_we), .i_ext_lock(i_ext_lock),
    .i_ext_addr(i_ext_addr), .i_ext_wdata(i_ext_wdata),
    .o_ext_gnt(o_ext_gnt), .o_ext_rvalid(o_ext_rvalid), .o_ext_rdata(o_ext_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 8'h5A : a * 8'd7 + 8'd3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // synchronous memory seen by the DUT
  logic [7:0] mem [256];
  bit mem_wr [256];
  always @(posedge i_clk)
    if (o_mem_en) begin
      if (o_mem_we) begin
        mem[o_mem_addr] = o_mem_wdata;
        mem_wr[o_mem_addr] = 1'b1;
      end else i_mem_rdata <= mem_wr[o_mem_addr] ? mem[o_mem_addr] : init_val(o_mem_addr);
    end

  // behavioural model: who was served last, lock ownership, locked grant count, forced CPU slot
  bit m_last_cpu, m_locked, m_force, m_cpu_rv, m_ext_rv, s_ec, s_ee;
  int m_cnt;
  logic [7:0] m_cpu_rd, m_ext_rd;
  logic [7:0] ref_mem [256];
  bit ref_wr [256];

  function automatic logic [7:0] ref_rd(input logic [7:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  always @(negedge i_clk) begin
    s_ec = 1'b0;
    s_ee = 1'b0;
    if (i_rstn) begin
      if (m_force) begin
        s_ec = i_cpu_req;
        s_ee = i_ext_req && !i_cpu_req;
      end else if (m_locked && i_ext_lock) s_ee = i_ext_req;
      else if (i_cpu_req && i_ext_req) begin
        if (m_last_cpu) s_ee = 1'b1;
        else s_ec = 1'b1;
      end else begin
        s_ec = i_cpu_req;
        s_ee = i_ext_req;
      end
    end
    chk("cpu_gnt", o_cpu_gnt, s_ec);
    chk("ext_gnt", o_ext_gnt, s_ee);
    chk("mem_en", o_mem_en, s_ec | s_ee);
    chk("mem_we", o_mem_we, s_ee ? i_ext_we : (s_ec & i_cpu_we));
    chk("mem_addr", o_mem_addr, s_ee ? i_ext_addr : s_ec ? i_cpu_addr : 8'h00);
    chk("mem_wdata", o_mem_wdata, s_ee ? i_ext_wdata : s_ec ? i_cpu_wdata : 8'h00);
    chk("cpu_rvalid", o_cpu_rvalid, i_rstn && m_cpu_rv);
    chk("ext_rvalid", o_ext_rvalid, i_rstn && m_ext_rv);
    chk("cpu_rdata", o_cpu_rdata, (i_rstn && m_cpu_rv) ? m_cpu_rd : 8'h00);
    chk("ext_rdata", o_ext_rdata, (i_rstn && m_ext_rv) ? m_ext_rd : 8'h00);
    chk("onehot0", $onehot0({o_cpu_gnt, o_ext_gnt}), 1);
    chk("en_is_or", o_mem_en, o_cpu_gnt | o_ext_gnt);
  end

  always @(posedge i_clk) begin
    if (!i_rstn) begin
      m_last_cpu = 0; m_locked = 0; m_force = 0; m_cnt = 0; m_cpu_rv = 0; m_ext_rv = 0;
    end else begin
      m_cpu_rv = s_ec && !i_cpu_we;
      m_ext_rv = s_ee && !i_ext_we;
      m_cpu_rd = ref_rd(i_cpu_addr);
      m_ext_rd = ref_rd(i_ext_addr);
      if (s_ec && i_cpu_we) begin ref_mem[i_cpu_addr] = i_cpu_wdata; ref_wr[i_cpu_addr] = 1; end
      if (s_ee && i_ext_we) begin ref_mem[i_ext_addr] = i_ext_wdata; ref_wr[i_ext_addr] = 1; end
      if (s_ec) m_last_cpu = 1;
      if (s_ee) m_last_cpu = 0;
      if (s_ee && i_ext_lock) begin
        m_cnt++;
        m_force = (m_cnt == LM);
        m_locked = !m_force;
        if (m_force) m_cnt = 0;
      end else if (m_force) begin
        m_force = 0;
        m_locked = i_ext_lock;
        m_cnt = 0;
      end else if (!(m_locked && i_ext_lock)) begin
        m_locked = 0;
        m_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_in();
    i_cpu_req = 0; i_cpu_we = 0; i_ext_req = 0; i_ext_we = 0; i_ext_lock = 0;
  endtask

  task automatic do_reset();
    i_rstn = 0;
    idle_in();
    step();
    step();
    i_rstn = 1;
  endtask

  initial begin
    logic [3:0] pat;
    int nc, ne, k, cpu_at;
    i_cpu_req = 1; i_ext_req = 1;
    #3;
    chk("rst_cpu_gnt", o_cpu_gnt, 0);
    chk("rst_ext_gnt", o_ext_gnt, 0);
    chk("rst_mem_en", o_mem_en, 0);
    step(); step();
    idle_in();
    i_rstn = 1;
    // CPU-only read of 0x10
    i_cpu_req = 1; i_cpu_addr = 8'h10;
    #3;
    chk("r22_gnt", o_cpu_gnt, 1);
    chk("r22_addr", o_mem_addr, 8'h10);
    step();
    idle_in();
    #3;
    chk("r22_rvalid", o_cpu_rvalid, 1);
    chk("r22_rdata", o_cpu_rdata, 8'h5A);
    step();
    // both requesting from reset alternate
    do_reset();
    i_cpu_req = 1; i_ext_req = 1; i_cpu_addr = 8'h01; i_ext_addr = 8'h02;
    pat = '0; nc = 0;
    for (int n = 0; n < 4; n++) begin
      #3;
      pat[n] = o_ext_gnt;
      nc += int'(o_cpu_gnt);
      step();
    end
    chk("r23_pattern", pat, 4'b1010);
    chk("r23_cpu_cnt", nc, 2);
    // locked write burst 0x00..0x13 with CPU waiting
    do_reset();
    k = 0; nc = 0; cpu_at = -1;
    i_ext_req = 1; i_ext_we = 1; i_ext_lock = 1;
    for (int n = 0; n < 40 && k < 20; n++) begin
      i_ext_addr = 8'(k);
      i_ext_wdata = 8'(k) ^ 8'hA5;
      i_cpu_req = (k > 0) && (nc == 0);
      i_cpu_addr = 8'h10;
      #3;
      if (o_cpu_gnt) begin nc++; cpu_at = k; end
      k += int'(o_ext_gnt);
      step();
    end
    idle_in();
    chk("r24_ext_grants", k, 20);
    chk("r24_cpu_grants", nc, 1);
    chk("r24_cpu_slot", cpu_at, 16);
    i_cpu_req = 1; i_cpu_addr = 8'h13;
    #3;
    chk("r24_rb_gnt", o_cpu_gnt, 1);
    step();
    idle_in();
    #3;
    chk("r24_rb_data", o_cpu_rdata, 8'hB6);
    step();
    // lock held across idle cycles without consuming the budget
    do_reset();
    ne = 0;
    i_ext_req = 1; i_ext_we = 1; i_ext_lock = 1;
    for (int n = 0; n < 5; n++) begin
      i_ext_addr = 8'(n + 32); i_ext_wdata = 8'(n);
      #3;
      ne += int'(o_ext_gnt);
      step();
    end
    chk("r25_pre", ne, 5);
    i_ext_req = 0; i_cpu_req = 1; i_cpu_addr = 8'h10;
    for (int n = 0; n < 3; n++) begin
      #3;
      chk("r25_idle_gnt", {o_cpu_gnt, o_ext_gnt}, 0);
      step();
    end
    i_ext_req = 1; ne = 0; cpu_at = -1;
    for (int n = 0; n < 40 && cpu_at < 0; n++) begin
      #3;
      if (o_cpu_gnt) cpu_at = ne;
      ne += int'(o_ext_gnt);
      step();
    end
    idle_in();
    chk("r25_resume", cpu_at, 11);
    // reset during a lock with a read about to return
    do_reset();
    i_ext_req = 1; i_ext_lock = 1; i_ext_we = 0; i_ext_addr = 8'h10;
    #3;
    chk("r26_gnt", o_ext_gnt, 1);
    i_rstn = 0;
    step();
    #3;
    chk("r26_rvalid", o_ext_rvalid, 0);
    chk("r26_rst_gnt", o_ext_gnt, 0);
    step();
    i_rstn = 1; i_ext_req = 0; i_cpu_req = 1; i_cpu_addr = 8'h10;
    #3;
    chk("r26_cpu_gnt", o_cpu_gnt, 1);
    chk("r26_rvalid2", o_ext_rvalid, 0);
    step();
    idle_in();
    // dropping the lock hands the cycle back to normal arbitration
    do_reset();
    i_ext_req = 1; i_ext_lock = 1; i_ext_we = 1; i_ext_addr = 8'h40; i_ext_wdata = 8'h11;
    step(); step();
    i_ext_lock = 0; i_cpu_req = 1; i_cpu_addr = 8'h40;
    #3;
    chk("rel_cpu_gnt", o_cpu_gnt, 1);
    chk("rel_ext_gnt", o_ext_gnt, 0);
    step();
    idle_in();
    #3;
    chk("rel_rdata", o_cpu_rdata, 8'h11);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 8, memory address width; DATA_W, 8, memory data width; LOCK_MAX, 16, maximum consecutive locked external grants.
REQ-002 Ports SHALL be (name direction width meaning):
 i_clk  in  1  single clock, rising edge;
 i_rstn  in  1  asynchronous active-low reset;
 i_cpu_req / i_cpu_we  in  1  CPU access request / write;
 i_cpu_addr / i_cpu_wdata  in  ADDR_W / DATA_W  CPU address / write data;
 o_cpu_gnt  out  1  CPU access issued this cycle;
 o_cpu_rvalid / o_cpu_rdata  out  1 / DATA_W  CPU read return;
 i_ext_req / i_ext_we / i_ext_lock  in  1  loader/debug request / write / burst lock;
 i_ext_addr / i_ext_wdata  in  ADDR_W / DATA_W  loader address / write data;
 o_ext_gnt  out  1  loader access issued this cycle;
 o_ext_rvalid / o_ext_rdata  out  1 / DATA_W  loader read return;
 o_mem_en / o_mem_we  out  1  memory enable / write;
 o_mem_addr / o_mem_wdata  out  ADDR_W / DATA_W  memory address / data;
 i_mem_rdata  in  DATA_W  synchronous memory read data, valid one cycle after o_mem_en.

Function
REQ-003 At most one of o_cpu_gnt, o_ext_gnt SHALL be high per cycle; grants are combinational from current requests and registered state.
REQ-004 o_mem_en SHALL equal o_cpu_gnt | o_ext_gnt; o_mem_we, o_mem_addr, o_mem_wdata SHALL be muxed from the granted port; they are 0 when no grant.
REQ-005 Single requester, not locked out: that requester SHALL be granted the same cycle.
REQ-006 Both requesting, state not ARB_LOCK: grant SHALL go to the port not granted most recently (round-robin bit rr; rr=0 favours CPU).
REQ-007 rr SHALL update on every grant to favour the other port next.
REQ-008 States SHALL be ARB_IDLE, ARB_CPU, ARB_EXT, ARB_LOCK, ARB_FORCE; the next state records the owner of the current cycle.
REQ-009 An ext grant with i_ext_lock=1 SHALL enter ARB_LOCK; in ARB_LOCK the CPU SHALL NOT be granted.
REQ-010 In ARB_LOCK, i_ext_lock=0 SHALL release the lock combinationally; normal arbitration then applies that cycle.
REQ-011 In ARB_LOCK, i_ext_req=0 with i_ext_lock=1 SHALL hold the lock with no grant; idle cycles do not count toward LOCK_MAX.
REQ-012 A lock counter SHALL count locked ext grants and clear on lock exit.
REQ-013 When the counter reaches LOCK_MAX, the FSM SHALL enter ARB_FORCE.
REQ-014 In ARB_FORCE the CPU SHALL have absolute priority for one cycle; the FSM then returns to ARB_LOCK if i_ext_lock=1, else follows REQ-008.
REQ-015 o_x_rvalid SHALL be registered: high exactly one cycle after a granted read (gnt & !we) on port x; o_x_rdata = i_mem_rdata, 0 when rvalid low.
REQ-016 Writes SHALL produce no rvalid.
REQ-017 Requesters SHALL hold req/addr/data until granted; dropping req before grant is legal and cancels the request.

Reset
REQ-018 While i_rstn=0: FSM = ARB_IDLE, rr=0, lock counter=0, rvalids=0; all grants and o_mem_* outputs SHALL be 0 regardless of requests.
REQ-019 Reset asserted mid-lock or with a read in flight SHALL discard the lock and the pending rvalid.

Structure
REQ-020 arb_state_t and default ADDR_W/DATA_W constants SHALL live in the shared edulent package.
REQ-021 The lock counter SHALL be a sub-module, arb_lock_timer (count enable, clear, terminal-count output).

Verification
REQ-022 CPU-only read of addr 0x10, memory holds 0x5A -> o_cpu_gnt same cycle; o_cpu_rvalid=1, o_cpu_rdata=0x5A next cycle.
REQ-023 Both request continuously from reset -> grants alternate CPU, EXT, CPU, EXT.
REQ-024 EXT locked write burst addr 0x00..0x13 with CPU requesting -> 16 ext grants, 1 CPU grant, then the remaining 4 ext grants.
REQ-025 EXT locks, then drops req for 3 cycles while the CPU requests -> no grants in those 3 cycles; counter unchanged.
REQ-026 i_rstn pulsed low during a lock, one cycle after an ext read -> o_ext_rvalid stays 0; after release, CPU request is granted immediately.
REQ-027 Every cycle: assert grant one-hot-or-zero and o_mem_en == (o_cpu_gnt | o_ext_gnt).
